alien_march_scheduler: RTL
==========================

ALIEN_MARCH_SCHEDULER -- requirements
Module: alien_march_scheduler

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 2, meaning frame ticks between march steps is BASE_PERIOD+1.
REQ-002 SHALL have parameter STEP_X, default 1, meaning horizontal pixels per step (2-bit, 1..3).
REQ-003 SHALL have parameter DROP_Y, default 2, meaning vertical pixels per edge drop (2-bit, 1..3).
REQ-004 SHALL have parameters LEFT_LIMIT, default 5, and RIGHT_LIMIT, default 603, meaning edge thresholds in pixels.
REQ-005 SHALL have parameter BOTTOM_LIMIT, default 440, meaning formation bottom Y that ends the game.
REQ-006 SHALL have port Pclk  input  1  pixel clock, all logic on rising edge.
REQ-007 SHALL have port Rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have ports xx, yy  input  10 each  current raster pixel position.
REQ-009 SHALL have port run  input  1  marching enable.
REQ-010 SHALL have port form_left  input  10  leftmost live alien X.
REQ-011 SHALL have port form_right  input  10  rightmost live alien X (left edge of that sprite).
REQ-012 SHALL have port form_bottom  input  10  lowest live alien bottom Y.
REQ-013 SHALL have port alive_count  input  6  live aliens, 0..55.
REQ-014 SHALL have ports X_off, Y_off  output  2 each  step offsets, valid only while step=1.
REQ-015 SHALL have ports dir  output  1 (1=right), step  output  1 (one-cycle move strobe), landed  output  1 (sticky).

Function
REQ-016 SHALL define frame tick as the single cycle where xx==639 and yy==479.
REQ-017 SHALL implement states IDLE, COUNT, STEP, DROP, LANDED.
REQ-018 IDLE -> COUNT when run=1 and alive_count!=0; frame counter cleared on entry to COUNT.
REQ-019 In COUNT, each frame tick: if frame_cnt >= period then frame_cnt<=0 and move to DROP when (dir=1 and form_right>=RIGHT_LIMIT) or (dir=0 and form_left<=LEFT_LIMIT), else to STEP; otherwise frame_cnt+1.
REQ-020 STEP lasts exactly one cycle: step=1, X_off=STEP_X, Y_off=0, then COUNT.
REQ-021 DROP lasts exactly one cycle: step=1, X_off=0, Y_off=DROP_Y, dir toggles, then LANDED if form_bottom+DROP_Y>=BOTTOM_LIMIT, else COUNT.
REQ-022 step SHALL rise exactly one Pclk after the qualifying frame tick; X_off=Y_off=0 whenever step=0.
REQ-023 Both edge conditions true together: direction SHALL follow dir only (no double drop).
REQ-024 run=0 or alive_count==0 in COUNT SHALL return to IDLE next cycle with frame_cnt cleared and dir held; a pending STEP/DROP cycle completes first.
REQ-025 LANDED SHALL hold landed=1, step=0 regardless of run until reset.
REQ-026 frame_cnt SHALL be 3 bits wide, saturating, never wrapping; comparison uses >= so a shrinking period takes effect at the next tick.

Reset
REQ-027 Rst_n=0 SHALL asynchronously force IDLE, frame_cnt=0, dir=1, step=0, X_off=0, Y_off=0, landed=0.
REQ-028 Reset deassertion mid-operation SHALL resume from IDLE on the next Pclk edge with no spurious step.

Configuration
REQ-029 Macro MARCH_SPEEDUP_EN defined: period = BASE_PERIOD for alive_count>=40, BASE_PERIOD/2 for 20..39, 0 (step every tick) for 1..19.
REQ-030 Macro MARCH_SPEEDUP_EN undefined: period = BASE_PERIOD constantly; alive_count used only for the zero check.

Verification
REQ-031 Reset, run=1, alive_count=55, form_left=100, form_right=300 -> step pulses every 3rd frame tick, X_off=1, Y_off=0, dir=1.
REQ-032 dir=1, form_right=603 at qualifying tick -> one DROP pulse X_off=0 Y_off=2, dir becomes 0; next step X_off=1 leftward.
REQ-033 form_bottom=438 at DROP -> landed=1 after that pulse, no further steps with run toggled.
REQ-034 run dropped for 5 frames mid-COUNT -> no steps, dir unchanged; resume restarts 3-tick spacing.
REQ-035 With MARCH_SPEEDUP_EN, alive_count 55->10 mid-count -> step at very next tick, then every tick.
REQ-036 Rst_n pulsed low during DROP cycle -> step=0 immediately, dir=1, landed=0.

Source files
------------

// File: rtl/alien_march_scheduler_if.sv
// Bundles the raster position, formation status and march-control outputs of
// alien_march_scheduler.
interface alien_march_scheduler_if;
    logic [9:0] xx;
    logic [9:0] yy;
    logic       run;
    logic [9:0] form_left;
    logic [9:0] form_right;
    logic [9:0] form_bottom;
    logic [5:0] alive_count;
    logic [1:0] X_off;
    logic [1:0] Y_off;
    logic       dir;
    logic       step;
    logic       landed;

    modport master (
        output xx, yy, run, form_left, form_right, form_bottom, alive_count,
        input  X_off, Y_off, dir, step, landed
    );

    modport slave (
        input  xx, yy, run, form_left, form_right, form_bottom, alive_count,
        output X_off, Y_off, dir, step, landed
    );
endinterface

// File: rtl/alien_march_scheduler.sv
// Paces the invader formation: one-cycle step/drop strobes on frame ticks, edge reversal, landing.
// Optional MARCH_SPEEDUP_EN shortens the step period as the number of live aliens falls.
module alien_march_scheduler #(
    parameter int unsigned BASE_PERIOD  = 2,
    parameter int unsigned STEP_X       = 1,
    parameter int unsigned DROP_Y       = 2,
    parameter int unsigned LEFT_LIMIT   = 5,
    parameter int unsigned RIGHT_LIMIT  = 603,
    parameter int unsigned BOTTOM_LIMIT = 440
) (
    input logic                    Pclk,
    input logic                    Rst_n,
    alien_march_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        STEP   = 3'd2,
        DROP   = 3'd3,
        LANDED = 3'd4
    } state_t;

    localparam logic [2:0]  BASE_P    = 3'(BASE_PERIOD);
    localparam logic [1:0]  STEP_X_V  = 2'(STEP_X);
    localparam logic [1:0]  DROP_Y_V  = 2'(DROP_Y);
    localparam logic [9:0]  LEFT_LIM  = 10'(LEFT_LIMIT);
    localparam logic [9:0]  RIGHT_LIM = 10'(RIGHT_LIMIT);
    localparam logic [10:0] BOTTOM_LIM = 11'(BOTTOM_LIMIT);

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  frame_cnt_r;
    logic [2:0]  frame_cnt_s;
    logic        dir_r;
    logic        dir_s;
    logic        landed_r;
    logic        landed_s;
    logic        step_r;
    logic        step_s;
    logic [1:0]  x_off_r;
    logic [1:0]  x_off_s;
    logic [1:0]  y_off_r;
    logic [1:0]  y_off_s;

    logic        frame_tick_s;
    logic        run_ok_s;
    logic        at_edge_s;
    logic        will_land_s;
    logic [10:0] bottom_sum_s;
    logic [2:0]  period_s;

    assign frame_tick_s = (bus.xx == 10'd639) && (bus.yy == 10'd479);
    assign run_ok_s     = bus.run && (bus.alive_count != 6'd0);
    // Direction alone selects which edge is tested, so a formation touching both never double-drops.
    assign at_edge_s    = dir_r ? (bus.form_right >= RIGHT_LIM) : (bus.form_left <= LEFT_LIM);
    assign bottom_sum_s = {1'b0, bus.form_bottom} + {9'd0, DROP_Y_V};
    assign will_land_s  = (bottom_sum_s >= BOTTOM_LIM);

`ifdef MARCH_SPEEDUP_EN
    // Period shrinks as the formation thins out.
    always_comb begin
        if (bus.alive_count >= 6'd40) begin
            period_s = BASE_P;
        end else if (bus.alive_count >= 6'd20) begin
            period_s = BASE_P >> 3'd1;
        end else begin
            period_s = 3'd0;
        end
    end
`else
    assign period_s = BASE_P;
`endif

    // Next-state, frame counter, direction and landing flag.
    always_comb begin
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        dir_s       = dir_r;
        landed_s    = landed_r;
        case (state_r)
            IDLE: begin
                frame_cnt_s = 3'd0;
                if (run_ok_s) begin
                    state_s = COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (!run_ok_s) begin
                    state_s     = IDLE;
                    frame_cnt_s = 3'd0;
                end else if (frame_tick_s) begin
                    if (frame_cnt_r >= period_s) begin
                        frame_cnt_s = 3'd0;
                        state_s     = at_edge_s ? DROP : STEP;
                    end else if (frame_cnt_r != 3'd7) begin
                        frame_cnt_s = frame_cnt_r + 3'd1;
                    end else begin
                        frame_cnt_s = frame_cnt_r;
                    end
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            STEP: begin
                state_s = COUNT;
            end
            DROP: begin
                dir_s = ~dir_r;
                if (will_land_s) begin
                    state_s  = LANDED;
                    landed_s = 1'b1;
                end else begin
                    state_s = COUNT;
                end
            end
            LANDED: begin
                state_s  = LANDED;
                landed_s = 1'b1;
            end
            default: begin
                state_s     = IDLE;
                frame_cnt_s = 3'd0;
            end
        endcase
    end

    // Strobe and offsets decoded from the upcoming state so they are registered.
    always_comb begin
        step_s  = 1'b0;
        x_off_s = 2'd0;
        y_off_s = 2'd0;
        case (state_s)
            STEP: begin
                step_s  = 1'b1;
                x_off_s = STEP_X_V;
            end
            DROP: begin
                step_s  = 1'b1;
                y_off_s = DROP_Y_V;
            end
            default: begin
                step_s  = 1'b0;
                x_off_s = 2'd0;
                y_off_s = 2'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Pclk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= IDLE;
            frame_cnt_r <= 3'd0;
            dir_r       <= 1'b1;
            landed_r    <= 1'b0;
            step_r      <= 1'b0;
            x_off_r     <= 2'd0;
            y_off_r     <= 2'd0;
        end else begin
            state_r     <= state_s;
            frame_cnt_r <= frame_cnt_s;
            dir_r       <= dir_s;
            landed_r    <= landed_s;
            step_r      <= step_s;
            x_off_r     <= x_off_s;
            y_off_r     <= y_off_s;
        end
    end

    assign bus.step   = step_r;
    assign bus.X_off  = x_off_r;
    assign bus.Y_off  = y_off_r;
    assign bus.dir    = dir_r;
    assign bus.landed = landed_r;

endmodule
